// File: rtl/trng_byte_packer_if.sv
// Word stream from the TRNG byte packer to the user I/O mux.
// Master drives data/valid, slave drives ready.
interface trng_byte_packer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/trng_byte_packer.sv
// Von Neumann corrects raw latch entropy and packs corrected bits into WIDTH-bit words.
// Latency: word valid the cycle after the edge sampling its pair-completing raw bit.
// Backpressure: one full word waits behind out_data, further bits drop; HEALTH_TEST_EN adds a repetition-count fault.
module trng_byte_packer #(
    parameter int WIDTH     = 8,
    parameter int REP_LIMIT = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enabled,
    input  logic               raw_bit,
    output logic               fault,
    trng_byte_packer_if.master stream
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(WIDTH);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("trng_byte_packer: WIDTH out of range");
    end
    if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_limit
        $error("trng_byte_packer: REP_LIMIT out of range");
    end

    typedef enum logic {
        IDLE,
        HAVE_FIRST
    } pair_state_t;

    pair_state_t      state_q, state_nxt;
    logic             first_q;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [CW-1:0]    count_q, count_nxt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             emit;
    logic             take;
    logic             load;
    logic             blocked;

`ifdef HEALTH_TEST_EN
    logic [7:0] run_q, run_nxt;
    logic       prev_q;
    logic       have_prev_q;
    logic       fault_q;

    // Runs count enabled samples only, so a disabled gap leaves the run intact.
    always_comb begin
        run_nxt = run_q;
        if (enabled) begin
            if (have_prev_q && (raw_bit == prev_q)) begin
                run_nxt = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
            end else begin
                run_nxt = 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q       <= 8'd0;
            prev_q      <= 1'b0;
            have_prev_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            if (enabled) begin
                run_q       <= run_nxt;
                prev_q      <= raw_bit;
                have_prev_q <= 1'b1;
            end
            if (run_nxt >= 8'(REP_LIMIT)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign fault   = fault_q;
    assign blocked = fault_q;
`else
    assign fault   = 1'b0;
    assign blocked = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        emit      = 1'b0;
        if (!enabled) begin
            state_nxt = IDLE;
        end else if (state_q == IDLE) begin
            state_nxt = HAVE_FIRST;
        end else begin
            state_nxt = IDLE;
            emit      = (raw_bit != first_q) && !blocked;
        end
    end

    // A full assembler either hands its word over this edge or holds it and drops new bits.
    always_comb begin
        take      = emit && (count_q != FULL);
        shift_nxt = shift_q;
        count_nxt = count_q;
        if (take) begin
            shift_nxt = {shift_q[WIDTH-2:0], first_q};
            count_nxt = count_q + CW'(1);
        end
        load = (count_nxt == FULL) && (!valid_q || stream.out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            shift_q <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (enabled && (state_q == IDLE)) begin
                first_q <= raw_bit;
            end
            if (blocked) begin
                shift_q <= '0;
                count_q <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (load) begin
                shift_q <= '0;
                count_q <= '0;
                data_q  <= shift_nxt;
                valid_q <= 1'b1;
            end else begin
                shift_q <= shift_nxt;
                count_q <= count_nxt;
                if (valid_q && stream.out_ready) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign stream.out_data  = data_q;
    assign stream.out_valid = valid_q && !blocked;

endmodule

// File: tb/tb_trng_byte_packer.sv
// Directed bench for trng_byte_packer: pair correction, packing, backpressure, gaps, reset, health fault.
module tb_trng_byte_packer;
`ifdef HEALTH_TEST_EN
    localparam bit HT = 1'b1;
`else
    localparam bit HT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic enabled;
    logic raw_bit;
    logic fault;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    trng_byte_packer_if #(.WIDTH(8)) bus ();

    trng_byte_packer #(
        .WIDTH    (8),
        .REP_LIMIT(32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enabled(enabled),
        .raw_bit(raw_bit),
        .fault  (fault),
        .stream (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        enabled = 1'b1;
        raw_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enabled = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Bit b is sent as pair (b, ~b); junk inserts an equal pair before each good pair.
    task automatic send_bits_of(input logic [7:0] w, input int hi, input int lo, input bit junk);
        for (int i = hi; i >= lo; i--) begin
            if (junk) begin
                send_bit(i[0]);
                send_bit(i[0]);
            end
            send_bit(w[i]);
            send_bit(~w[i]);
        end
    endtask

    task automatic send_word_but_last(input logic [7:0] w, input bit junk);
        send_bits_of(w, 7, 1, junk);
        if (junk) begin
            send_bit(1'b0);
            send_bit(1'b0);
        end
        send_bit(w[0]);
    endtask

    task automatic send_word(input logic [7:0] w);
        send_word_but_last(w, 1'b0);
        send_bit(~w[0]);
    endtask

    initial begin
        reset         = 1'b1;
        enabled       = 1'b0;
        raw_bit       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'h00);
        check("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Scenario 1: plain stream, latency
        bus.out_ready = 1'b1;
        send_word_but_last(8'hA5, 1'b0);
        check("s1_valid_early", 32'(bus.out_valid), 32'd0);
        send_bit(1'b0);
        check("s1_valid", 32'(bus.out_valid), 32'd1);
        check("s1_data", 32'(bus.out_data), 32'hA5);
        check("s1_fault", 32'(fault), 32'd0);
        idle(1);
        check("s1_valid_drop", 32'(bus.out_valid), 32'd0);

        // Scenario 2: 00/11 pairs interleaved
        send_word_but_last(8'hA5, 1'b1);
        check("s2_valid_early", 32'(bus.out_valid), 32'd0);
        send_bit(1'b0);
        check("s2_valid", 32'(bus.out_valid), 32'd1);
        check("s2_data", 32'(bus.out_data), 32'hA5);
        idle(1);

        // Scenario 3: backpressure with a pending full word
        bus.out_ready = 1'b0;
        send_word(8'hA5);
        check("s3_valid_a", 32'(bus.out_valid), 32'd1);
        check("s3_data_a", 32'(bus.out_data), 32'hA5);
        send_word(8'h3C);
        check("s3_hold_data", 32'(bus.out_data), 32'hA5);
        check("s3_hold_valid", 32'(bus.out_valid), 32'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("s3_hold_data2", 32'(bus.out_data), 32'hA5);
        @(negedge clk);
        enabled       = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("s3_b2b_valid", 32'(bus.out_valid), 32'd1);
        check("s3_b2b_data", 32'(bus.out_data), 32'h3C);
        @(posedge clk);
        #1;
        check("s3_drain_valid", 32'(bus.out_valid), 32'd0);
        send_word(8'hA5);
        check("s3_after_data", 32'(bus.out_data), 32'hA5);
        check("s3_after_valid", 32'(bus.out_valid), 32'd1);
        idle(1);

        // Scenario 4: enabled drop mid-pair discards the half pair
        send_bits_of(8'hA5, 7, 5, 1'b0);
        send_bit(1'b1);
        idle(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bits_of(8'hA5, 3, 1, 1'b0);
        send_bit(1'b1);
        check("s4_valid_early", 32'(bus.out_valid), 32'd0);
        send_bit(1'b0);
        check("s4_valid", 32'(bus.out_valid), 32'd1);
        check("s4_data", 32'(bus.out_data), 32'hA5);
        idle(1);

        // Scenario 5: reset with a held word and a partial word
        bus.out_ready = 1'b0;
        send_word(8'hA5);
        check("s5_pre_valid", 32'(bus.out_valid), 32'd1);
        send_bits_of(8'h3C, 7, 3, 1'b0);
        @(negedge clk);
        reset   = 1'b1;
        enabled = 1'b0;
        @(posedge clk);
        #1;
        check("s5_rst_valid", 32'(bus.out_valid), 32'd0);
        check("s5_rst_data", 32'(bus.out_data), 32'h00);
        @(negedge clk);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        send_word(8'h3C);
        check("s5_valid", 32'(bus.out_valid), 32'd1);
        check("s5_data", 32'(bus.out_data), 32'h3C);
        idle(1);

        // Scenario 6: repetition-count health test
        send_bit(1'b0);
        send_bit(1'b0);
        repeat (31) send_bit(1'b1);
        check("s6_fault_31", 32'(fault), 32'd0);
        send_bit(1'b1);
        check("s6_fault_32", 32'(fault), 32'(HT));
        idle(1);
        send_word(8'hA5);
        check("s6_valid", 32'(bus.out_valid), 32'(!HT));
        check("s6_word", 32'(bus.out_valid ? bus.out_data : 8'h00), HT ? 32'h00 : 32'hA5);
        check("s6_fault_sticky", 32'(fault), 32'(HT));
        @(negedge clk);
        reset   = 1'b1;
        enabled = 1'b0;
        @(posedge clk);
        #1;
        check("s6_rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h3C);
        check("s6_post_valid", 32'(bus.out_valid), 32'd1);
        check("s6_post_data", 32'(bus.out_data), 32'h3C);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
